// File: rtl/fifo8x9_ctrl_pkg.sv
// Shared types and constants for the 8x9 FIFO control front-end.
// The optional almost-full/almost-empty outputs are enabled by FIFO_CTRL_ALMOST_FLAGS_EN.
package fifo8x9_ctrl_pkg;

  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_CNT_W  = 4;
  localparam int FIFO_DATA_W = 9;
  localparam int FIFO_AF_LVL = 6;
  localparam int FIFO_AE_LVL = 2;

  typedef enum logic [0:0] {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  typedef logic [FIFO_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fifo8x9_ctrl.sv
// Push/pop arbiter and occupancy tracker driving the 8x9 FIFO storage strobes.
// Optional almost_full/almost_empty ports are enabled by FIFO_CTRL_ALMOST_FLAGS_EN.
module fifo8x9_ctrl
  import fifo8x9_ctrl_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  parameter int AF_LVL = FIFO_AF_LVL,
  parameter int AE_LVL = FIFO_AE_LVL,
`endif
  parameter int CNT_W  = FIFO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  output logic             push_rdy,
  output logic             pop_rdy,
  output logic             wren,
  output logic             rden,
  output logic             WrInc,
  output logic             RdInc,
  output logic             WrPtrClr,
  output logic             RdPtrClr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nx;

  assign full  = (count == CNT_MAX);
  assign empty = (count == CNT_ZERO);

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  assign almost_full  = (count >= CNT_W'(AF_LVL));
  assign almost_empty = (count <= CNT_W'(AE_LVL));
`endif

  // State register: reset lands in CLR so the storage pointers get cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_CLR;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: CLR is a single-cycle pulse; a flush request re-enters it.
  always_comb begin
    state_nx = state;
    case (state)
      ST_CLR: state_nx = ST_RUN;
      ST_RUN: begin
        if (clr) begin
          state_nx = ST_CLR;
        end else begin
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_CLR;
    endcase
  end

  // Grants and strobes; pop wins when data exists since the storage block
  // can only advance one pointer per cycle. A reset cycle grants nothing.
  always_comb begin
    push_rdy = 1'b0;
    pop_rdy  = 1'b0;
    wren     = 1'b0;
    rden     = 1'b0;
    WrPtrClr = 1'b0;
    RdPtrClr = 1'b0;
    case (state)
      ST_CLR: begin
        WrPtrClr = 1'b1;
        RdPtrClr = 1'b1;
      end
      ST_RUN: begin
        if (rst) begin
          pop_rdy  = !empty;
          push_rdy = !full && !(pop && !empty);
          wren     = push && push_rdy;
          rden     = pop && pop_rdy;
        end else begin
          pop_rdy  = 1'b0;
          push_rdy = 1'b0;
        end
      end
      default: begin
        WrPtrClr = 1'b1;
        RdPtrClr = 1'b1;
      end
    endcase
  end

  assign WrInc = wren;
  assign RdInc = rden;

  // Occupancy counter; grants are already gated by full/empty so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= CNT_ZERO;
    end else if ((state != ST_RUN) || clr) begin
      count <= CNT_ZERO;
    end else if (wren) begin
      count <= count + CNT_ONE;
    end else if (rden) begin
      count <= count - CNT_ONE;
    end else begin
      count <= count;
    end
  end

  // Sticky error flags survive a flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if ((state == ST_RUN) && push && full) begin
        ovf <= 1'b1;
      end else begin
        ovf <= ovf;
      end
      if ((state == ST_RUN) && pop && empty) begin
        udf <= 1'b1;
      end else begin
        udf <= udf;
      end
    end
  end

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Self-checking bench for fifo8x9_ctrl: a cycle model predicts grants each
// cycle and queues the expected registered state, compared after the next edge.
module tb_fifo8x9_ctrl;
  import fifo8x9_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic push_rdy, pop_rdy, wren, rden, WrInc, RdInc, WrPtrClr, RdPtrClr;
  logic [3:0] count;
  logic full, empty, ovf, udf;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  logic almost_full, almost_empty;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic       m_known = 1'b0;
  logic       m_run = 1'b0;
  logic [3:0] m_count = 4'd0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] sb_q[$];

  // Grants observed in the most recent step
  logic g_push_rdy, g_pop_rdy, g_wren, g_rden, g_wrptrclr;

  fifo8x9_ctrl dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
    .push_rdy(push_rdy), .pop_rdy(pop_rdy), .wren(wren), .rden(rden),
    .WrInc(WrInc), .RdInc(RdInc), .WrPtrClr(WrPtrClr), .RdPtrClr(RdPtrClr),
    .count(count), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // One clock cycle: check last edge's registers, drive inputs, check grants, advance model.
  task automatic step(input logic r, input logic c, input logic pu, input logic po);
    logic [7:0] exp_s, got_s, exp_g, got_g;
    logic e_push_rdy, e_pop_rdy, e_wren, e_rden;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      exp_s = sb_q.pop_front();
      got_s = {count, full, empty, ovf, udf};
      checks++;
      if (got_s !== exp_s) begin
        failures++;
        $display("FAIL sb_regs {count,full,empty,ovf,udf} got=%b exp=%b", got_s, exp_s);
      end
    end
    rst = r; clr = c; push = pu; pop = po;
    #1;
    e_push_rdy = 1'b0; e_pop_rdy = 1'b0; e_wren = 1'b0; e_rden = 1'b0;
    if (m_known) begin
      if (!m_run) begin
        exp_g = 8'b0000_0011;
      end else begin
        if (r) begin
          e_pop_rdy  = (m_count != 4'd0);
          e_push_rdy = (m_count != 4'd8) && !(po && (m_count != 4'd0));
          e_wren     = pu && e_push_rdy;
          e_rden     = po && e_pop_rdy;
        end
        exp_g = {e_push_rdy, e_pop_rdy, e_wren, e_rden, e_wren, e_rden, 2'b00};
      end
      got_g = {push_rdy, pop_rdy, wren, rden, WrInc, RdInc, WrPtrClr, RdPtrClr};
      checks++;
      if (got_g !== exp_g) begin
        failures++;
        $display("FAIL sb_grants {prdy,qrdy,wren,rden,winc,rinc,wclr,rclr} got=%b exp=%b", got_g, exp_g);
      end
    end
    g_push_rdy = push_rdy; g_pop_rdy = pop_rdy; g_wren = wren; g_rden = rden; g_wrptrclr = WrPtrClr;
    if (!r) begin
      m_known = 1'b1; m_run = 1'b0; m_count = 4'd0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (m_known) begin
      if (!m_run) begin
        m_run = 1'b1; m_count = 4'd0;
      end else begin
        if (pu && (m_count == 4'd8)) m_ovf = 1'b1;
        if (po && (m_count == 4'd0)) m_udf = 1'b1;
        if (c) begin
          m_run = 1'b0; m_count = 4'd0;
        end else if (e_wren) begin
          m_count = m_count + 4'd1;
        end else if (e_rden) begin
          m_count = m_count - 4'd1;
        end
      end
    end
    if (m_known) sb_q.push_back({m_count, (m_count == 4'd8), (m_count == 4'd0), m_ovf, m_udf});
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (g_wrptrclr !== 1'b1) begin failures++; $display("FAIL reset_clr_strobe got=%b exp=1", g_wrptrclr); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({g_wrptrclr, RdPtrClr} !== 2'b00) begin failures++; $display("FAIL reset_clr_drop got=%b%b exp=00", g_wrptrclr, RdPtrClr); end
    checks++;
    if ({count, full, empty, ovf, udf} !== 8'b0000_0100) begin
      failures++; $display("FAIL reset_values got=%b exp=00000100", {count, full, empty, ovf, udf});
    end
  endtask

  task automatic test_fill();
    int nw = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      nw += int'(g_wren);
      if (i >= 8) begin
        checks++;
        if (g_push_rdy !== 1'b0) begin failures++; $display("FAIL fill_push_rdy cycle=%0d got=%b exp=0", i + 1, g_push_rdy); end
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (nw != 8) begin failures++; $display("FAIL fill_wren_cycles got=%0d exp=8", nw); end
    checks++;
    if ({count, full, ovf} !== 6'b1000_1_1) begin failures++; $display("FAIL fill_full got=%b exp=100011", {count, full, ovf}); end
  endtask

  task automatic test_drain();
    int nr = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      nr += int'(g_rden);
      if (i == 8) begin
        checks++;
        if (udf !== 1'b0) begin failures++; $display("FAIL drain_udf_early got=%b exp=0", udf); end
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (nr != 8) begin failures++; $display("FAIL drain_rden_cycles got=%0d exp=8", nr); end
    checks++;
    if ({count, empty, udf} !== 6'b0000_1_1) begin failures++; $display("FAIL drain_empty got=%b exp=000011", {count, empty, udf}); end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({g_rden, g_wren, g_push_rdy} !== 3'b100) begin
      failures++; $display("FAIL simul_nonempty {rden,wren,push_rdy} got=%b exp=100", {g_rden, g_wren, g_push_rdy});
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({count, ovf} !== 5'b0010_0) begin failures++; $display("FAIL simul_count2 got=%b exp=00100", {count, ovf}); end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({g_wren, g_rden} !== 2'b10) begin failures++; $display("FAIL simul_empty {wren,rden} got=%b exp=10", {g_wren, g_rden}); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({count, udf} !== 5'b0001_1) begin failures++; $display("FAIL simul_count1_udf got=%b exp=00011", {count, udf}); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({g_wrptrclr, RdPtrClr, g_wren, g_rden, g_push_rdy, g_pop_rdy} !== 6'b110000) begin
      failures++; $display("FAIL flush_clr_cycle got=%b exp=110000", {g_wrptrclr, RdPtrClr, g_wren, g_rden, g_push_rdy, g_pop_rdy});
    end
    checks++;
    if (count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({g_wrptrclr, count, ovf, udf} !== 7'b0_0000_01) begin
      failures++; $display("FAIL flush_run_flags got=%b exp=0000001", {g_wrptrclr, count, ovf, udf});
    end
  endtask

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  task automatic test_almost();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({almost_full, almost_empty} !== 2'b01) begin failures++; $display("FAIL almost_reset got=%b exp=01", {almost_full, almost_empty}); end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({count, almost_full} !== 5'b0110_1) begin failures++; $display("FAIL almost_full6 got=%b exp=01101", {count, almost_full}); end
    for (int c = 5; c >= 3; c--) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({almost_full, almost_empty} !== 2'b00) begin
        failures++; $display("FAIL almost_mid count=%0d got=%b exp=00", count, {almost_full, almost_empty});
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({count, almost_empty} !== 5'b0010_1) begin failures++; $display("FAIL almost_empty2 got=%b exp=00101", {count, almost_empty}); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_flush();
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    test_almost();
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
